// File: rtl/pcla_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pcla_pkg
// Summary  : Shared defaults and operation encoding for the pipelined CLA adder.
// Revision : 1.0 - initial release
// ============================================================================
package pcla_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_BLOCK = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage
`default_nettype wire

// File: rtl/cla_n_bit_block.sv
`default_nettype none
// ============================================================================
// Module   : cla_n_bit_block
// Summary  : Combinational N-bit carry-lookahead slice with block G/P outputs.
// Revision : 1.0 - initial release
// ============================================================================
module cla_n_bit_block
    import pcla_pkg::*;
#(
    parameter int N = DEFAULT_BLOCK
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         g,
    output logic         p,
    output logic         c_msb,
    output logic         cout
);

    logic [N-1:0] w_gen;
    logic [N-1:0] w_prop;
    logic [N:0]   w_c;
    logic         w_acc;
    logic         w_run;

    assign w_gen  = a & b;
    assign w_prop = a ^ b;

    // Each carry is a flat sum of products back to cin rather than a ripple chain.
    always_comb begin
        w_c    = '0;
        w_c[0] = cin;
        w_acc  = 1'b0;
        w_run  = 1'b1;
        g      = 1'b0;
        p      = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_acc = 1'b0;
            w_run = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_acc = w_acc | (w_run & w_gen[j]);
                w_run = w_run & w_prop[j];
            end
            w_c[i+1] = w_acc | (w_run & cin);
            if (i == N - 1) begin
                g = w_acc;
                p = w_run;
            end
        end
    end

    assign sum   = w_prop ^ w_c[N-1:0];
    assign c_msb = w_c[N-1];
    assign cout  = w_c[N];

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Summary  : Add/subtract pipeline, one CLA slice per stage, global stall.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder
    import pcla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int BLOCK = DEFAULT_BLOCK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out
);

    localparam int STAGES = WIDTH / BLOCK;

    if (((WIDTH % BLOCK) != 0) || (BLOCK < 2)) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK and BLOCK >= 2");
    end

    logic w_sub;
    logic w_adv;

    assign w_sub    = (sub == OP_SUB);
    assign w_adv    = ~g_stage[STAGES-1].r_valid | out_ready;
    assign in_ready = reset | w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_b_in;
        logic [WIDTH-1:0] w_s_in;
        logic [WIDTH-1:0] w_and_in;
        logic [WIDTH-1:0] w_or_in;
        logic             w_c_in;
        logic             w_v_in;
        logic [BLOCK-1:0] w_sum_sl;
        logic [WIDTH-1:0] w_s_next;
        logic             w_g;
        logic             w_p;
        logic             w_cmsb;
        logic             w_cout;
        logic             w_unused;

        logic             r_valid;
        logic             r_carry;
        logic             r_ovf;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_sum;
        logic [WIDTH-1:0] r_and;
        logic [WIDTH-1:0] r_or;

        if (k == 0) begin : g_first
            // B is conditioned once here; the bitwise results use the original B.
            assign w_a_in   = a;
            assign w_b_in   = b ^ {WIDTH{w_sub}};
            assign w_s_in   = '0;
            assign w_and_in = a & b;
            assign w_or_in  = a | b;
            assign w_c_in   = w_sub;
            assign w_v_in   = in_valid;
        end else begin : g_next
            assign w_a_in   = g_stage[k-1].r_a;
            assign w_b_in   = g_stage[k-1].r_b;
            assign w_s_in   = g_stage[k-1].r_sum;
            assign w_and_in = g_stage[k-1].r_and;
            assign w_or_in  = g_stage[k-1].r_or;
            assign w_c_in   = g_stage[k-1].r_carry;
            assign w_v_in   = g_stage[k-1].r_valid;
        end

        cla_n_bit_block #(
            .N (BLOCK)
        ) u_cla (
            .a     (w_a_in[k*BLOCK +: BLOCK]),
            .b     (w_b_in[k*BLOCK +: BLOCK]),
            .cin   (w_c_in),
            .sum   (w_sum_sl),
            .g     (w_g),
            .p     (w_p),
            .c_msb (w_cmsb),
            .cout  (w_cout)
        );

        always_comb begin
            w_s_next                     = w_s_in;
            w_s_next[k*BLOCK +: BLOCK]   = w_sum_sl;
        end

        // Last-stage operand copies and block G/P feed nothing downstream.
        assign w_unused = ^{w_g, w_p, r_a, r_b, r_ovf};

        always_ff @(posedge clock) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
                r_a     <= '0;
                r_b     <= '0;
                r_sum   <= '0;
                r_and   <= '0;
                r_or    <= '0;
            end else if (w_adv) begin
                r_valid <= w_v_in;
                r_carry <= w_cout;
                r_ovf   <= w_cmsb ^ w_cout;
                r_a     <= w_a_in;
                r_b     <= w_b_in;
                r_sum   <= w_s_next;
                r_and   <= w_and_in;
                r_or    <= w_or_in;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign sum       = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_carry;
    assign overflow  = g_stage[STAGES-1].r_ovf;
    assign and_out   = g_stage[STAGES-1].r_and;
    assign or_out    = g_stage[STAGES-1].r_or;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_cla_adder
// Summary  : Scoreboard bench for pipelined_cla_adder (32/8 plus a 16/4 copy).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_cla_adder;
    import pcla_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, sub, out_valid, out_ready, cout, overflow;
    logic [31:0] a, b, sum, and_out, or_out;

    logic        in_valid2, in_ready2, sub2, out_valid2, cout2, overflow2;
    logic [15:0] a2, b2, sum2, and2, or2;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [31:0] land;
        logic [31:0] lor;
    } exp_t;

    exp_t sb[$];
    int   n_checks    = 0;
    int   n_errors    = 0;
    int   n_issued    = 0;
    int   n_delivered = 0;
    bit   rand_done;

    always #5 clock = ~clock;

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .and_out(and_out), .or_out(or_out)
    );

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .sub(sub2), .out_valid(out_valid2), .out_ready(1'b1),
        .sum(sum2), .cout(cout2), .overflow(overflow2), .and_out(and2), .or_out(or2)
    );

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t            e;
        longint          sx, sy, r;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = (s == OP_SUB) ? sx - sy : sx + sy;
        e.sum  = (s == OP_SUB) ? x - y : x + y;
        e.cout = (s == OP_SUB) ? (x >= y) : ((ux + uy) > 64'hFFFF_FFFF);
        e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.land = x & y;
        e.lor  = x | y;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1; holds the operands until they are accepted.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
        bit done;
        done     = 1'b0;
        a        = x;
        b        = y;
        sub      = s;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clock);
            if (in_ready && !reset) begin
                sb.push_back(model(x, y, s));
                n_issued++;
                done = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected acceptance");
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out_valid && n < 30);
    endtask

    task automatic drain(input string name);
        repeat (12) @(posedge clock);
        #1;
        check({name, "_queue_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_delivered"}, 64'(n_delivered), 64'(n_issued));
    endtask

    // Monitor: compare the head while out_valid is up, pop on transfer.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output: got sum=%0h expected no result", sum);
                end else begin
                    e = sb[0];
                    check("sum", {32'd0, sum}, {32'd0, e.sum});
                    check("cout", {63'd0, cout}, {63'd0, e.cout});
                    check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
                    check("and_out", {32'd0, and_out}, {32'd0, e.land});
                    check("or_out", {32'd0, or_out}, {32'd0, e.lor});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_delivered++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        in_valid2 = 1'b0;
        a2        = '0;
        b2        = '0;
        sub2      = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_sum", {32'd0, sum}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Directed corner cases, each through an idle pipeline.
        issue(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
        wait_out(n);
        check("latency_ovf", 64'(n), 64'd4);
        @(posedge clock); #1;
        issue(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
        wait_out(n);
        check("latency_ripple", 64'(n), 64'd4);
        @(posedge clock); #1;
        issue(32'd5, 32'd7, OP_SUB);
        wait_out(n);
        check("latency_sub", 64'(n), 64'd4);
        @(posedge clock); #1;

        // Eight back-to-back ops; the observer counts from the first presentation cycle.
        fork
            begin
                for (int i = 0; i < 8; i++) issue($urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            begin
                int m;
                wait_out(m);
                check("b2b_first_valid_cycle", 64'(m), 64'd5);
                for (int i = 1; i < 8; i++) begin
                    @(negedge clock);
                    check("b2b_consecutive_valid", {63'd0, out_valid}, 64'd1);
                end
            end
        join
        drain("b2b");

        // Fill the pipeline with the consumer stalled, then hold for three cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(pick(), pick(), 1'($urandom_range(0, 1)));
        fork
            issue(pick(), pick(), 1'($urandom_range(0, 1)));
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clock);
                    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                    check("stall_out_valid", {63'd0, out_valid}, 64'd1);
                end
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        drain("stall");

        // Random operands, random gaps and random back-pressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    if (($urandom & 3) == 0) begin
                        @(posedge clock); #1;
                    end else begin
                        issue(pick(), pick(), 1'($urandom_range(0, 1)));
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("random");

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) issue(pick(), pick(), 1'($urandom_range(0, 1)));
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        check("in_ready_during_reset", {63'd0, in_ready}, 64'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_sum", {32'd0, sum}, 64'd0);
        check("post_reset_flags", {62'd0, cout, overflow}, 64'd0);
        check("post_reset_logic", {and_out, or_out}, 64'd0);
        check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("no_stale_result", {63'd0, out_valid}, 64'd0);
        end
        @(posedge clock); #1;

        // 16-bit / 4-bit block configuration.
        a2        = 16'h8000;
        b2        = 16'h0001;
        sub2      = OP_SUB;
        in_valid2 = 1'b1;
        @(negedge clock);
        check("w16_in_ready", {63'd0, in_ready2}, 64'd1);
        @(posedge clock); #1;
        in_valid2 = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!out_valid2 && n < 30);
        check("w16_latency", 64'(n), 64'd4);
        check("w16_sum", {48'd0, sum2}, 64'h7FFF);
        check("w16_overflow", {63'd0, overflow2}, 64'd1);
        check("w16_cout", {63'd0, cout2}, 64'd1);
        check("w16_and_or", {32'd0, and2, or2}, 64'h0000_8001);
        @(posedge clock); #1;
        @(negedge clock);
        check("w16_single_result", {63'd0, out_valid2}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
